// File: rtl/rv_p4_pkg.sv
// Shared RV-P4 pipeline types: PHV geometry, packet metadata and action entry layout.
package rv_p4_pkg;

  localparam int unsigned PHV_BITS       = 256;
  localparam int unsigned ACT_ENTRY_BITS = 128;
  localparam int unsigned ACT_ID_BITS    = 16;
  localparam int unsigned ACT_PARAM_BITS = 112;
  localparam int unsigned CNT_BITS       = 32;

  // An all-zero action id decodes as no-operation in mau_alu.
  localparam logic [ACT_ID_BITS-1:0] OP_NOP = '0;

  typedef struct packed {
    logic [7:0]  ingress_port;
    logic [15:0] pkt_len;
    logic [6:0]  flags;
    logic        drop;
  } phv_meta_t;

  typedef struct packed {
    logic [ACT_ID_BITS-1:0]    id;
    logic [ACT_PARAM_BITS-1:0] params;
  } act_entry_t;

  // Saturating increment for statistics counters.
  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

endpackage

// File: rtl/mau_act_sram.sv
// Action memory: one write port, one synchronous read port, write-first on same-address collision.
// Contents are intentionally not reset so a memory macro wrapper can drop in later.
module mau_act_sram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 128,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_bypass;

  assign w_bypass = i_wr_en && (i_wr_addr == i_rd_addr);

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    o_rd_data <= w_bypass ? i_wr_data : r_mem[i_rd_addr];
  end

endmodule

// File: rtl/mau_action_fetch.sv
// MAU action slice front stage: fetches the action entry (or default on miss) and aligns it
// with the 2-cycle delayed PHV/meta for mau_alu; also owns action-memory config and hit/miss stats.
module mau_action_fetch
  import rv_p4_pkg::*;
#(
  parameter int unsigned ACT_DEPTH = 1024,
  parameter int unsigned ACT_AW    = $clog2(ACT_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PHV_BITS-1:0]       phv_in,
  input  phv_meta_t                 meta_in,
  input  logic                      valid_in,
  input  logic                      match_hit,
  input  logic [ACT_AW-1:0]         match_addr,
  input  logic                      cfg_wr_en,
  input  logic [ACT_AW-1:0]         cfg_addr,
  input  logic [ACT_ENTRY_BITS-1:0] cfg_wdata,
  input  logic                      cfg_def_wr_en,
  input  logic [ACT_ENTRY_BITS-1:0] cfg_def_wdata,
  input  logic                      cnt_clr,
  output logic [PHV_BITS-1:0]       phv_out,
  output phv_meta_t                 meta_out,
  output logic                      valid_out,
  output logic [ACT_ID_BITS-1:0]    action_id,
  output logic [ACT_PARAM_BITS-1:0] action_params,
  output logic                      action_valid,
  output logic [CNT_BITS-1:0]       hit_cnt,
  output logic [CNT_BITS-1:0]       miss_cnt
);

  logic [ACT_ENTRY_BITS-1:0] w_sram_rd_raw;
  act_entry_t                w_sram_rd;
  act_entry_t                w_def_next;
  act_entry_t                w_sel;
  logic                      w_count;

  act_entry_t                r_def_act;
  act_entry_t                r_def_snap_s1;
  logic [PHV_BITS-1:0]       r_phv_s1;
  phv_meta_t                 r_meta_s1;
  logic                      r_valid_s1;
  logic                      r_hit_s1;
  logic                      r_act_s1;

  logic [PHV_BITS-1:0]       r_phv_s2;
  phv_meta_t                 r_meta_s2;
  logic                      r_valid_s2;
  logic                      r_act_valid_s2;
  act_entry_t                r_act_s2;

  logic [CNT_BITS-1:0]       r_hit_cnt;
  logic [CNT_BITS-1:0]       r_miss_cnt;

  mau_act_sram #(
    .DEPTH (ACT_DEPTH),
    .WIDTH (ACT_ENTRY_BITS),
    .AW    (ACT_AW)
  ) u_act_sram (
    .clk       (clk),
    .i_wr_en   (cfg_wr_en),
    .i_wr_addr (cfg_addr),
    .i_wr_data (cfg_wdata),
    .i_rd_addr (match_addr),
    .o_rd_data (w_sram_rd_raw)
  );

  assign w_sram_rd  = act_entry_t'(w_sram_rd_raw);
  // A default write in the same cycle as a packet is visible to that packet.
  assign w_def_next = cfg_def_wr_en ? act_entry_t'(cfg_def_wdata) : r_def_act;
  assign w_count    = valid_in && !meta_in.drop;

  always_comb begin
    w_sel = r_def_snap_s1;
    if (r_hit_s1) begin
      w_sel = w_sram_rd;
    end
  end

  // Stage 1: packet capture and default snapshot; SRAM read runs in parallel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_def_act     <= '0;
      r_def_snap_s1 <= '0;
      r_phv_s1      <= '0;
      r_meta_s1     <= '0;
      r_valid_s1    <= 1'b0;
      r_hit_s1      <= 1'b0;
      r_act_s1      <= 1'b0;
    end else begin
      r_def_act     <= w_def_next;
      r_def_snap_s1 <= w_def_next;
      r_phv_s1      <= phv_in;
      r_meta_s1     <= meta_in;
      r_valid_s1    <= valid_in;
      r_hit_s1      <= valid_in && match_hit;
      r_act_s1      <= w_count;
    end
  end

  // Stage 2: select entry and register outputs; non-applied packets carry a zero entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phv_s2       <= '0;
      r_meta_s2      <= '0;
      r_valid_s2     <= 1'b0;
      r_act_valid_s2 <= 1'b0;
      r_act_s2       <= '0;
    end else begin
      r_phv_s2       <= r_phv_s1;
      r_meta_s2      <= r_meta_s1;
      r_valid_s2     <= r_valid_s1;
      r_act_valid_s2 <= r_act_s1;
      if (r_act_s1) begin
        r_act_s2 <= w_sel;
      end else begin
        r_act_s2.id     <= OP_NOP;
        r_act_s2.params <= '0;
      end
    end
  end

  // Statistics: clear wins over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (cnt_clr) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_count) begin
      if (match_hit) begin
        r_hit_cnt <= sat_inc(r_hit_cnt);
      end else begin
        r_miss_cnt <= sat_inc(r_miss_cnt);
      end
    end
  end

  assign phv_out       = r_phv_s2;
  assign meta_out      = r_meta_s2;
  assign valid_out     = r_valid_s2;
  assign action_valid  = r_act_valid_s2;
  assign action_id     = r_act_s2.id;
  assign action_params = r_act_s2.params;
  assign hit_cnt       = r_hit_cnt;
  assign miss_cnt      = r_miss_cnt;

endmodule

// File: tb/tb_mau_action_fetch.sv
// Directed self-checking bench for mau_action_fetch: lookup, default, bypasses, drop,
// back-to-back ordering, counter saturation/clear and mid-stream reset.
module tb_mau_action_fetch;
  import rv_p4_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned CW = PHV_BITS;

  localparam logic [111:0] P3  = 112'h3003_3003_3003_3003_3003_3003_3003;
  localparam logic [111:0] P5  = 112'h5005_5005_5005_5005_5005_5005_5005;
  localparam logic [111:0] P7  = 112'h7007_7007_7007_7007_7007_7007_7007;
  localparam logic [111:0] P9  = 112'h9009_9009_9009_9009_9009_9009_9009;
  localparam logic [111:0] PA  = 112'hA00A_A00A_A00A_A00A_A00A_A00A_A00A;
  localparam logic [111:0] PDB = 112'hDB0D_DB0D_DB0D_DB0D_DB0D_DB0D_DB0D;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [PHV_BITS-1:0]       phv_in;
  phv_meta_t                 meta_in;
  logic                      valid_in;
  logic                      match_hit;
  logic [AW-1:0]             match_addr;
  logic                      cfg_wr_en;
  logic [AW-1:0]             cfg_addr;
  logic [ACT_ENTRY_BITS-1:0] cfg_wdata;
  logic                      cfg_def_wr_en;
  logic [ACT_ENTRY_BITS-1:0] cfg_def_wdata;
  logic                      cnt_clr;
  logic [PHV_BITS-1:0]       phv_out;
  phv_meta_t                 meta_out;
  logic                      valid_out;
  logic [15:0]               action_id;
  logic [111:0]              action_params;
  logic                      action_valid;
  logic [31:0]               hit_cnt;
  logic [31:0]               miss_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [PHV_BITS-1:0] b_phv  [4];
  logic                b_hit  [4];
  logic [AW-1:0]       b_addr [4];
  logic [15:0]         b_id   [4];
  logic [111:0]        b_par  [4];

  mau_action_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .phv_in        (phv_in),
    .meta_in       (meta_in),
    .valid_in      (valid_in),
    .match_hit     (match_hit),
    .match_addr    (match_addr),
    .cfg_wr_en     (cfg_wr_en),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .cfg_def_wr_en (cfg_def_wr_en),
    .cfg_def_wdata (cfg_def_wdata),
    .cnt_clr       (cnt_clr),
    .phv_out       (phv_out),
    .meta_out      (meta_out),
    .valid_out     (valid_out),
    .action_id     (action_id),
    .action_params (action_params),
    .action_valid  (action_valid),
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_act(input string tag, input logic vo, input logic av,
                           input logic [15:0] id, input logic [111:0] par);
    check_eq({tag, "_valid"},  CW'(valid_out),     CW'(vo));
    check_eq({tag, "_actv"},   CW'(action_valid),  CW'(av));
    check_eq({tag, "_id"},     CW'(action_id),     CW'(id));
    check_eq({tag, "_params"}, CW'(action_params), CW'(par));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    valid_in      = 1'b0;
    match_hit     = 1'b0;
    match_addr    = '0;
    meta_in       = '0;
    phv_in        = '0;
    cfg_wr_en     = 1'b0;
    cfg_def_wr_en = 1'b0;
    cnt_clr       = 1'b0;
  endtask

  task automatic cfg_write(input logic [AW-1:0] addr, input logic [127:0] data);
    cfg_wr_en = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    step();
    cfg_wr_en = 1'b0;
  endtask

  task automatic def_write(input logic [127:0] data);
    cfg_def_wr_en = 1'b1;
    cfg_def_wdata = data;
    step();
    cfg_def_wr_en = 1'b0;
  endtask

  task automatic drive_pkt(input logic [PHV_BITS-1:0] phv, input logic hit,
                           input logic [AW-1:0] addr, input logic drop);
    valid_in        = 1'b1;
    phv_in          = phv;
    match_hit       = hit;
    match_addr      = addr;
    meta_in         = '0;
    meta_in.pkt_len = phv[15:0];
    meta_in.drop    = drop;
  endtask

  task automatic send(input logic [PHV_BITS-1:0] phv, input logic hit,
                      input logic [AW-1:0] addr, input logic drop);
    drive_pkt(phv, hit, addr, drop);
    step();
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      b_phv[i] = {8{32'hB2B0_0000 | 32'(i)}};
    end
    b_hit[0] = 1'b1; b_addr[0] = 10'd3; b_id[0] = 16'h2000; b_par[0] = P3;
    b_hit[1] = 1'b0; b_addr[1] = 10'd3; b_id[1] = 16'hB000; b_par[1] = PDB;
    b_hit[2] = 1'b1; b_addr[2] = 10'd9; b_id[2] = 16'h3000; b_par[2] = P9;
    b_hit[3] = 1'b0; b_addr[3] = 10'd9; b_id[3] = 16'hB000; b_par[3] = PDB;

    rst_n         = 1'b0;
    cfg_addr      = '0;
    cfg_wdata     = '0;
    cfg_def_wdata = '0;
    idle_inputs();
    step();
    step();
    check_act("rst", 1'b0, 1'b0, 16'h0, 112'h0);
    check_eq("rst_hit_cnt",  CW'(hit_cnt),  CW'(0));
    check_eq("rst_miss_cnt", CW'(miss_cnt), CW'(0));
    check_eq("rst_phv",      phv_out,       CW'(0));
    rst_n = 1'b1;
    step();

    cfg_write(10'd5, {16'h1000, P5});
    cfg_write(10'd3, {16'h2000, P3});
    cfg_write(10'd9, {16'h3000, P9});
    cfg_write(10'd7, {16'h7777, P7});
    def_write({16'h9000, 112'h0});
    step();

    // Hit on a preloaded entry.
    send({8{32'h1111_0005}}, 1'b1, 10'd5, 1'b0);
    step();
    check_act("hit5", 1'b1, 1'b1, 16'h1000, P5);
    check_eq("hit5_phv",  phv_out,       {8{32'h1111_0005}});
    check_eq("hit5_hcnt", CW'(hit_cnt),  CW'(1));
    check_eq("hit5_mcnt", CW'(miss_cnt), CW'(0));

    // Miss selects the default entry.
    send({8{32'h2222_0000}}, 1'b0, 10'd5, 1'b0);
    step();
    check_act("miss", 1'b1, 1'b1, 16'h9000, 112'h0);
    check_eq("miss_mcnt", CW'(miss_cnt), CW'(1));
    check_eq("miss_hcnt", CW'(hit_cnt),  CW'(1));

    // Same-cycle write to the looked-up address returns the new data.
    drive_pkt({8{32'h3333_0007}}, 1'b1, 10'd7, 1'b0);
    cfg_wr_en = 1'b1;
    cfg_addr  = 10'd7;
    cfg_wdata = {16'hA000, PA};
    step();
    idle_inputs();
    step();
    check_act("wbyp", 1'b1, 1'b1, 16'hA000, PA);
    check_eq("wbyp_hcnt", CW'(hit_cnt), CW'(2));

    // Same-cycle default write is seen by the missing packet.
    drive_pkt({8{32'h4444_0000}}, 1'b0, 10'd0, 1'b0);
    cfg_def_wr_en = 1'b1;
    cfg_def_wdata = {16'hB000, PDB};
    step();
    idle_inputs();
    step();
    check_act("dbyp", 1'b1, 1'b1, 16'hB000, PDB);
    check_eq("dbyp_mcnt", CW'(miss_cnt), CW'(2));

    // Already-dropped packet passes through with no action and no count.
    send({8{32'h5555_0005}}, 1'b1, 10'd5, 1'b1);
    step();
    check_act("drop", 1'b1, 1'b0, 16'h0, 112'h0);
    check_eq("drop_meta", CW'(meta_out.drop), CW'(1));
    check_eq("drop_phv",  phv_out,            {8{32'h5555_0005}});
    check_eq("drop_hcnt", CW'(hit_cnt),       CW'(2));
    check_eq("drop_mcnt", CW'(miss_cnt),      CW'(2));

    // Back-to-back packets emerge in order on consecutive cycles.
    for (int i = 0; i < 6; i++) begin
      if (i >= 2) begin
        check_act($sformatf("b2b%0d", i - 2), 1'b1, 1'b1, b_id[i-2], b_par[i-2]);
        check_eq($sformatf("b2b%0d_phv", i - 2), phv_out, b_phv[i-2]);
        check_eq($sformatf("b2b%0d_len", i - 2), CW'(meta_out.pkt_len), CW'(b_phv[i-2][15:0]));
      end
      if (i < 4) drive_pkt(b_phv[i], b_hit[i], b_addr[i], 1'b0);
      else       idle_inputs();
      step();
    end
    check_act("idle", 1'b0, 1'b0, 16'h0, 112'h0);
    check_eq("b2b_hcnt", CW'(hit_cnt),  CW'(4));
    check_eq("b2b_mcnt", CW'(miss_cnt), CW'(4));

    // Hit counter saturation.
    force dut.r_hit_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_hit_cnt;
    send({8{32'h6666_0001}}, 1'b1, 10'd5, 1'b0);
    check_eq("sat1_hcnt", CW'(hit_cnt), CW'(32'hFFFF_FFFF));
    send({8{32'h6666_0002}}, 1'b1, 10'd5, 1'b0);
    check_eq("sat2_hcnt", CW'(hit_cnt), CW'(32'hFFFF_FFFF));
    send({8{32'h6666_0003}}, 1'b1, 10'd5, 1'b0);
    check_eq("sat3_hcnt", CW'(hit_cnt),  CW'(32'hFFFF_FFFF));
    check_eq("sat3_mcnt", CW'(miss_cnt), CW'(4));

    // Clear beats a coincident increment.
    drive_pkt({8{32'h7777_0005}}, 1'b1, 10'd5, 1'b0);
    cnt_clr = 1'b1;
    step();
    idle_inputs();
    check_eq("clr_hcnt", CW'(hit_cnt),  CW'(0));
    check_eq("clr_mcnt", CW'(miss_cnt), CW'(0));
    send({8{32'h7777_0006}}, 1'b1, 10'd5, 1'b0);
    check_eq("postclr_hcnt", CW'(hit_cnt), CW'(1));

    // Reset asserted while packets are in flight.
    drive_pkt({8{32'h8888_0001}}, 1'b1, 10'd5, 1'b0);
    step();
    drive_pkt({8{32'h8888_0002}}, 1'b1, 10'd3, 1'b0);
    step();
    idle_inputs();
    check_act("prerst", 1'b1, 1'b1, 16'h1000, P5);
    check_eq("prerst_hcnt", CW'(hit_cnt), CW'(3));
    rst_n = 1'b0;
    #1;
    check_act("midrst", 1'b0, 1'b0, 16'h0, 112'h0);
    check_eq("midrst_phv",  phv_out,       CW'(0));
    check_eq("midrst_hcnt", CW'(hit_cnt),  CW'(0));
    check_eq("midrst_mcnt", CW'(miss_cnt), CW'(0));
    step();
    rst_n = 1'b1;
    step();
    check_eq("postrst1_valid", CW'(valid_out), CW'(0));
    step();
    check_eq("postrst2_valid", CW'(valid_out), CW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
